ddr4_axi_fifo_rr_sched: RTL and testbench

// Round-robin scheduler/controller for one external shallow shift-register FIFO in the AXI slave.

---
 rtl/ddr4_axi_fifo_rr_sched.sv | 157 +++++++++++++++
 tb/tb_ddr4_axi_fifo_rr_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_axi_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_axi_fifo_rr_sched
// Purpose  : Round-robin merge of C_NUM_REQ valid/ready request streams into
//            one external shift-register FIFO, each beat tagged with its
//            source ID, plus a registered valid/ready drain of that FIFO.
//            Pushes are never issued while the FIFO is full and pops are
//            never issued while it is empty.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_axi_fifo_rr_sched #(
  parameter int C_NUM_REQ  = 2,
  parameter int C_IDW      = 1,
  parameter int C_WIDTH    = 8,
  parameter int C_AWIDTH   = 4,
  parameter int C_DEPTH    = 16,
  parameter int C_PKT_LOCK = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [C_NUM_REQ-1:0]         s_valid,
  output logic [C_NUM_REQ-1:0]         s_ready,
  input  logic [C_NUM_REQ-1:0]         s_last,
  input  logic [C_NUM_REQ*C_WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [C_WIDTH-1:0]           m_data,
  output logic [C_IDW-1:0]             m_id,
  output logic                         fifo_rst,
  output logic                         fifo_wr_en,
  output logic                         fifo_rd_en,
  output logic [C_IDW+C_WIDTH-1:0]     fifo_din,
  input  logic [C_IDW+C_WIDTH-1:0]     fifo_dout,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic [C_AWIDTH:0]            fifo_level
);

  // Requester 0 must win the first arbitration after reset.
  localparam logic [C_IDW-1:0]  RR_RESET = C_IDW'(C_NUM_REQ - 1);
  localparam logic [C_AWIDTH:0] LVL_ONE  = (C_AWIDTH + 1)'(1);
  localparam logic [C_AWIDTH:0] LVL_MAX  = (C_AWIDTH + 1)'(C_DEPTH);

  logic [C_IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [C_IDW-1:0]   lock_id_q, lock_id_d;
  logic               m_valid_q, m_valid_d;
  logic [C_WIDTH-1:0] m_data_q, m_data_d;
  logic [C_IDW-1:0]   m_id_q, m_id_d;
  logic [C_AWIDTH:0]  level_q, level_d;

  logic               eligible;
  logic               gnt_vld;
  logic [C_IDW-1:0]   gnt_idx;
  logic [C_IDW-1:0]   cand;
  logic [C_WIDTH-1:0] push_data;
  logic               push;
  logic               pop;

  // Round-robin search starting just after the last granted requester; a lock restricts it to lock_id.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    eligible = !fifo_full && !rst && (level_q != LVL_MAX);
    for (int off = 1; off <= C_NUM_REQ; off++) begin
      cand = C_IDW'((int'(rr_ptr_q) + off) % C_NUM_REQ);
      if (eligible && !gnt_vld && s_valid[cand] && (!lock_q || (cand == lock_id_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot ready and payload mux for the granted requester.
  always_comb begin
    s_ready   = '0;
    push_data = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == C_IDW'(i))) begin
        s_ready[i] = 1'b1;
        push_data  = s_data[i*C_WIDTH +: C_WIDTH];
      end
    end
  end

  assign push = gnt_vld;
  assign pop  = !fifo_empty && (!m_valid_q || m_ready);

  // Next-state for pointer, packet lock, output register and occupancy.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    level_d   = level_q;

    if (push) begin
      rr_ptr_d = gnt_idx;
      if (C_PKT_LOCK != 0) begin
        if (!s_last[gnt_idx]) begin
          lock_d    = 1'b1;
          lock_id_d = gnt_idx;
        end else begin
          lock_d    = 1'b0;
        end
      end
    end

    if (pop) begin
      m_valid_d          = 1'b1;
      {m_id_d, m_data_d} = fifo_dout;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // State registers; reset also discards whatever the output register holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= RR_RESET;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      level_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      level_q   <= level_d;
    end
  end

  assign fifo_rst   = rst;
  assign fifo_wr_en = push;
  assign fifo_rd_en = pop;
  assign fifo_din   = {gnt_idx, push_data};
  assign fifo_level = level_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_id       = m_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_axi_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_axi_fifo_rr_sched
// Purpose  : Scoreboard bench. Instance 0 runs without packet lock, instance
//            1 with packet lock; each has its own shift-register FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_axi_fifo_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_valid    [2];
  logic [1:0]  s_ready    [2];
  logic [1:0]  s_last     [2];
  logic [15:0] s_data     [2];
  logic        m_valid    [2];
  logic        m_ready    [2];
  logic [7:0]  m_data     [2];
  logic [0:0]  m_id       [2];
  logic        fifo_rst   [2];
  logic        fifo_wr_en [2];
  logic        fifo_rd_en [2];
  logic [8:0]  fifo_din   [2];
  logic [8:0]  fifo_dout  [2];
  logic        fifo_full  [2];
  logic        fifo_empty [2];
  logic [4:0]  fifo_level [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];

  always #5 clk = ~clk;

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_inst
      ddr4_axi_fifo_rr_sched #(
        .C_NUM_REQ(2), .C_IDW(1), .C_WIDTH(8), .C_AWIDTH(4), .C_DEPTH(16), .C_PKT_LOCK(k)
      ) u_dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[k]), .s_ready(s_ready[k]), .s_last(s_last[k]), .s_data(s_data[k]),
        .m_valid(m_valid[k]), .m_ready(m_ready[k]), .m_data(m_data[k]), .m_id(m_id[k]),
        .fifo_rst(fifo_rst[k]), .fifo_wr_en(fifo_wr_en[k]), .fifo_rd_en(fifo_rd_en[k]),
        .fifo_din(fifo_din[k]), .fifo_dout(fifo_dout[k]), .fifo_full(fifo_full[k]),
        .fifo_empty(fifo_empty[k]), .fifo_level(fifo_level[k])
      );

      // Shift-register FIFO model, head at mem[0].
      logic [8:0] mem [16];
      int cnt = 0;
      always @(posedge clk) begin : p_fifo
        logic [8:0] t [16];
        int n;
        if (fifo_rst[k]) begin
          cnt <= 0;
        end else begin
          t = mem;
          n = cnt;
          if (fifo_rd_en[k] && n > 0) begin
            for (int i = 0; i < 15; i++) t[i] = t[i+1];
            n--;
          end
          if (fifo_wr_en[k] && n < 16) begin
            t[n] = fifo_din[k];
            n++;
          end
          mem <= t;
          cnt <= n;
        end
      end
      assign fifo_dout[k]  = mem[0];
      assign fifo_full[k]  = (cnt == 16);
      assign fifo_empty[k] = (cnt == 0);

      // Overrun / underrun guard on the FIFO control strobes.
      always @(negedge clk) begin
        if (!rst && fifo_wr_en[k]) begin
          n_tests++;
          if (fifo_full[k]) begin
            n_fail++;
            $display("FAIL inst%0d wr_when_full: wr_en=1 full=%0b required full=0", k, fifo_full[k]);
          end
        end
        if (!rst && fifo_rd_en[k]) begin
          n_tests++;
          if (fifo_empty[k]) begin
            n_fail++;
            $display("FAIL inst%0d rd_when_empty: rd_en=1 empty=%0b required empty=0", k, fifo_empty[k]);
          end
        end
      end
    end
  endgenerate

  // Output monitors: pop the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    if (!rst && m_valid[0] && m_ready[0]) begin
      n_tests++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL inst0 out_beat: got %0h with nothing expected", {m_id[0], m_data[0]});
      end else begin
        logic [8:0] e;
        e = exp_a.pop_front();
        if ({m_id[0], m_data[0]} !== e) begin
          n_fail++;
          $display("FAIL inst0 out_beat: got {id,data}=%0h required %0h", {m_id[0], m_data[0]}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid[1] && m_ready[1]) begin
      n_tests++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL inst1 out_beat: got %0h with nothing expected", {m_id[1], m_data[1]});
      end else begin
        logic [8:0] e;
        e = exp_b.pop_front();
        if ({m_id[1], m_data[1]} !== e) begin
          n_fail++;
          $display("FAIL inst1 out_beat: got {id,data}=%0h required %0h", {m_id[1], m_data[1]}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards apply to the following edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Packet-lock stimulus table for instance 1.
  logic [1:0]  t4_valid [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10};
  logic [1:0]  t4_last  [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
  logic [15:0] t4_data  [8] = '{16'h8070, 16'h8071, 16'h8072, 16'h8073,
                                16'h8273, 16'h8274, 16'h8274, 16'h8274};
  logic [1:0]  t4_rdy   [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
  logic [8:0]  t4_exp   [8] = '{9'h070, 9'h071, 9'h072, 9'h180, 9'h073, 9'h000, 9'h074, 9'h182};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 2'b00; s_last[i] = 2'b11; s_data[i] = 16'h0; m_ready[i] = 1'b1;
    end
    s_valid[0] = 2'b11;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready[0]), 32'h0);
    chk("rst_fifo_rst", 32'(fifo_rst[0]), 32'h1);
    chk("rst_m_valid", 32'(m_valid[0]), 32'h0);
    chk("rst_level", 32'(fifo_level[0]), 32'h0);
    chk("rst_m_data", 32'({m_id[0], m_data[0]}), 32'h0);

    // Single beat
    step();
    rst = 1'b0;
    s_valid[0] = 2'b01; s_data[0] = 16'h00A5;
    exp_a.push_back(9'h0A5);
    @(negedge clk);
    chk("t1_s_ready", 32'(s_ready[0]), 32'h1);
    chk("t1_wr_en", 32'(fifo_wr_en[0]), 32'h1);
    chk("t1_din", 32'(fifo_din[0]), 32'h0A5);
    step();
    s_valid[0] = 2'b00;
    @(negedge clk);
    chk("t1_level1", 32'(fifo_level[0]), 32'h1);
    chk("t1_mvalid_early", 32'(m_valid[0]), 32'h0);
    step();
    @(negedge clk);
    chk("t1_mvalid", 32'(m_valid[0]), 32'h1);
    chk("t1_level0", 32'(fifo_level[0]), 32'h0);
    step();

    // Packet lock on instance 1
    for (int c = 0; c < 8; c++) begin
      s_valid[1] = t4_valid[c]; s_last[1] = t4_last[c]; s_data[1] = t4_data[c];
      if (t4_rdy[c] != 2'b00) exp_b.push_back(t4_exp[c]);
      @(negedge clk);
      chk($sformatf("t4_s_ready_c%0d", c), 32'(s_ready[1]), 32'(t4_rdy[c]));
      step();
    end
    s_valid[1] = 2'b00;
    repeat (4) step();

    // Reset pulse so requester 0 wins first again
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Fairness
    for (int i = 0; i < 6; i++) begin
      s_valid[0] = 2'b11;
      s_data[0]  = {8'(8'h20 + i), 8'(8'h10 + i)};
      exp_a.push_back((i % 2 == 1) ? {1'b1, 8'(8'h20 + i)} : {1'b0, 8'(8'h10 + i)});
      @(negedge clk);
      chk($sformatf("t2_s_ready_b%0d", i), 32'(s_ready[0]), (i % 2 == 1) ? 32'h2 : 32'h1);
      step();
    end
    s_valid[0] = 2'b00;
    repeat (4) step();

    // Backpressure
    m_ready[0] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      s_valid[0] = 2'b01;
      s_data[0]  = {8'h00, 8'(8'h40 + ((j < 17) ? j : 17))};
      if (j <= 16) exp_a.push_back({1'b0, 8'(8'h40 + j)});
      @(negedge clk);
      chk($sformatf("t3_s_ready_b%0d", j), 32'(s_ready[0]), (j <= 16) ? 32'h1 : 32'h0);
      step();
    end
    s_valid[0] = 2'b00;
    @(negedge clk);
    chk("t3_level16", 32'(fifo_level[0]), 32'd16);
    chk("t3_m_valid", 32'(m_valid[0]), 32'h1);
    step();
    m_ready[0] = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("t3_drained", 32'(fifo_level[0]), 32'h0);
    chk("t3_sb_empty", 32'(exp_a.size()), 32'h0);

    // Concurrent push/pop
    step();
    m_ready[0] = 1'b0;
    s_valid[0] = 2'b01; s_data[0] = 16'h0060; exp_a.push_back(9'h060);
    step();
    s_data[0] = 16'h0061; exp_a.push_back(9'h061);
    step();
    m_ready[0] = 1'b1;
    s_data[0] = 16'h0062; exp_a.push_back(9'h062);
    @(negedge clk);
    chk("t5_pre_level", 32'(fifo_level[0]), 32'h1);
    chk("t5_wr_en", 32'(fifo_wr_en[0]), 32'h1);
    chk("t5_rd_en", 32'(fifo_rd_en[0]), 32'h1);
    step();
    s_valid[0] = 2'b00;
    @(negedge clk);
    chk("t5_level", 32'(fifo_level[0]), 32'h1);
    chk("t5_m_valid", 32'(m_valid[0]), 32'h1);
    repeat (4) step();

    // Reset mid-stream: these beats are dropped, so nothing is expected for them
    m_ready[0] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      s_valid[0] = 2'b01; s_data[0] = {8'h00, 8'(8'h90 + j)};
      step();
    end
    s_valid[0] = 2'b00;
    @(negedge clk);
    chk("t6_level5", 32'(fifo_level[0]), 32'd5);
    chk("t6_m_valid1", 32'(m_valid[0]), 32'h1);
    step();
    rst = 1'b1;
    s_valid[0] = 2'b11; s_data[0] = 16'hB1B0;
    @(negedge clk);
    chk("t6_s_ready_rst", 32'(s_ready[0]), 32'h0);
    chk("t6_fifo_rst", 32'(fifo_rst[0]), 32'h1);
    step();
    rst = 1'b0;
    exp_a.push_back(9'h0B0);
    @(negedge clk);
    chk("t6_m_valid0", 32'(m_valid[0]), 32'h0);
    chk("t6_level0", 32'(fifo_level[0]), 32'h0);
    chk("t6_grant0", 32'(s_ready[0]), 32'h1);
    step();
    s_valid[0] = 2'b00;
    m_ready[0] = 1'b1;
    repeat (5) step();

    @(negedge clk);
    chk("sb_a_empty", 32'(exp_a.size()), 32'h0);
    chk("sb_b_empty", 32'(exp_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
